// File: rtl/key_feeder.sv
// key_feeder: latches the expanded key from key_schedule and streams it one
// round-key byte per valid/ready transfer to the round engine, in encrypt
// order (byte 0 first) or decrypt order (byte ROUNDS-1 first).
//
// Optional feature macro: KEY_FEEDER_ABORT_EN
//   When defined, adds input i_abort. Asserting it while streaming drops the
//   rest of the stream and returns to IDLE without a done pulse.
//   When undefined, every stream always runs to completion.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for start; shadow register holds the last loaded key
// SEND  | o_valid high, presenting shadow byte [cnt] until accepted
// FIN   | one-cycle done pulse after the final transfer; start ignored
module key_feeder #(
  parameter int ROUNDS = 56,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ROUNDS*8-1:0]   i_kk,
  input  logic                  i_decrypt,
`ifdef KEY_FEEDER_ABORT_EN
  input  logic                  i_abort,
`endif
  output logic [7:0]            o_key,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [CNT_W-1:0]      o_round,
  output logic                  busy,
  output logic                  done
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t                 state;
  logic [ROUNDS-1:0][7:0] shadow;
  logic                   dec;
  logic [CNT_W-1:0]       cnt;
  logic                   last_byte;
  logic                   abort_req;

  // The final byte depends on direction: top index for encrypt, 0 for decrypt.
  assign last_byte = dec ? (cnt == '0) : (cnt == LAST_IDX);

`ifdef KEY_FEEDER_ABORT_EN
  assign abort_req = i_abort;
`else
  assign abort_req = 1'b0;
`endif

  // Byte mux from registered state only; forced to zero when nothing is offered.
  assign o_key   = o_valid ? shadow[cnt] : 8'h00;
  assign o_round = cnt;

  // Sequencer: load on start, step the counter per transfer, pulse done at the end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      shadow  <= '0;
      dec     <= 1'b0;
      cnt     <= '0;
      o_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            shadow  <= i_kk;
            dec     <= i_decrypt;
            cnt     <= i_decrypt ? LAST_IDX : '0;
            o_valid <= 1'b1;
            busy    <= 1'b1;
            state   <= SEND;
          end
        end
        SEND: begin
          if (abort_req) begin
            // A transfer on this edge still reaches the consumer; the rest is dropped.
            cnt     <= '0;
            o_valid <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else if (i_ready) begin
            if (last_byte) begin
              // Counter holds at the final index rather than wrapping.
              o_valid <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= FIN;
            end else begin
              cnt <= dec ? (cnt - 1'b1) : (cnt + 1'b1);
            end
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          o_valid <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/key_feeder.md
Name: key_feeder

Overview:
- Reader/consumer side of the key schedule output.
- Latches the 56-byte expanded key produced by key_schedule (o_kk) and streams it one round-key byte per transfer to the block cipher core over a valid/ready handshake.
- Issues bytes in encrypt order (byte 0 first) or decrypt order (byte ROUNDS-1 first).
- Sits between key_schedule and the block cipher / decipher round engine.

Parameters:
- ROUNDS, 56, number of round-key bytes; i_kk width is ROUNDS*8.
- CNT_W, 6, width of the round counter and o_round; must satisfy 2**CNT_W >= ROUNDS.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to load i_kk and begin streaming.
- i_kk  in  ROUNDS*8  expanded key; byte k = i_kk[8k+7:8k].
- i_decrypt  in  1  order select, sampled with start: 0 = byte 0..ROUNDS-1, 1 = byte ROUNDS-1..0.
- o_key  out  8  current round-key byte.
- o_valid  out  1  o_key/o_round valid.
- i_ready  in  1  consumer accepts the byte this cycle.
- o_round  out  CNT_W  index k of the byte on o_key.
- busy  out  1  high from the cycle after accepted start until the last transfer completes.
- done  out  1  one-cycle pulse after the last transfer.

Behaviour:
- States: IDLE, SEND, FIN.
- Reset (rst low, asynchronous): state IDLE, key shadow register cleared, counter 0, o_key 0, o_valid 0, o_round 0, busy 0, done 0.
- IDLE:
  - start=1 at rising edge n: latch i_kk into the shadow register, latch i_decrypt, set the counter to 0 (encrypt) or ROUNDS-1 (decrypt), go to SEND.
  - From cycle n+1: busy=1, o_valid=1, o_key/o_round present the first byte.
- SEND:
  - Transfer occurs on a rising edge with o_valid=1 and i_ready=1.
  - On transfer, step the counter (+1 encrypt, -1 decrypt).
  - o_key/o_round hold stable while i_ready=0 (no bubbles, no skips).
  - Transfer of the final byte (counter ROUNDS-1 encrypt, 0 decrypt) moves the state to FIN: o_valid=0, busy=0, done=1 for exactly one cycle.
  - Counter never wraps.
- FIN: unconditionally returns to IDLE next edge; done drops.
- start while busy (SEND) or in FIN: ignored; shadow register unchanged.
- i_kk changes after load: no effect on the stream in progress.
- start in the same cycle as the done pulse: ignored.
- start in the first IDLE cycle after FIN: accepted.
- i_ready=1 continuously: ROUNDS transfers on ROUNDS consecutive edges; start-to-done latency is ROUNDS+1 cycles (done high in cycle n+ROUNDS+1).
- o_key is driven from the shadow register through a byte mux indexed by the counter; output registered or combinational from registered state, with no combinational path from i_ready to o_valid.
- Reset asserted mid-stream: immediate return to IDLE reset values; no done pulse.

Optional Feature:
- Macro KEY_FEEDER_ABORT_EN.
- Defined:
  - Adds input i_abort (1 bit).
  - i_abort=1 at an edge while in SEND: next cycle state IDLE, o_valid=0, busy=0, done stays 0, counter reset to 0.
  - A transfer coinciding with abort is still counted by the consumer; the feeder discards the remaining bytes.
  - i_abort in IDLE/FIN: no effect.
- Not defined: port absent; the stream always runs to completion.

Test Plan:
- Encrypt, i_ready held 1, i_kk byte k = k (byte 55 = 0x37): start, then o_key = 0x00, 0x01 ... 0x37 on consecutive cycles with o_round = 0..55. done pulses exactly once, at start+57 cycles; busy high for 56 cycles.
- Decrypt, same i_kk: first o_key = 0x37 with o_round = 55, last o_key = 0x00 with o_round = 0, then done.
- Backpressure: i_ready toggles 1,0,0,1 repeating during encrypt. o_key holds while i_ready=0; all 56 bytes are delivered in order with none duplicated or lost.
- Start while busy with a different i_kk (all 0xFF) at round 10: the stream continues with the original bytes. Start on the cycle after done is accepted and streams 0xFF.
- Reset: drive rst low at round 20 of a stream. Outputs go to 0 asynchronously with no done pulse; a new start after rst high streams correctly from byte 0.
- With KEY_FEEDER_ABORT_EN: i_abort at round 30 gives o_valid=0 and busy=0 next cycle with done never asserted; a subsequent start streams all 56 bytes.
